// File: rtl/fp32_acc_pkg.sv
// Shared types and defaults for the FP32 packet accumulator.
// Imported by fp32_add and fp32_accum_ctrl.
package fp32_acc_pkg;

   localparam int DWIDTH_DEF = 32;
   localparam int EWIDTH_DEF = 8;
   localparam int MWIDTH_DEF = 23;
   localparam int BIAS_DEF   = 127;
   localparam int CWIDTH_DEF = 16;

   localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE,
      ACC,
      WAIT,
      DONE
   } state_t;

endpackage

// File: rtl/fp32_add.sv
// Combinational IEEE-754 single adder, round-to-nearest-even.
// Subnormal results flush to zero; inf/NaN operands raise Exception.
module fp32_add
   import fp32_acc_pkg::*;
#(
   parameter int DWIDTH = DWIDTH_DEF,
   parameter int EWIDTH = EWIDTH_DEF,
   parameter int MWIDTH = MWIDTH_DEF,
   parameter int BIAS   = BIAS_DEF
) (
   input  logic [DWIDTH-1:0] a_operand,
   input  logic [DWIDTH-1:0] b_operand,
   input  logic              AddBar_Sub,
   output logic              Exception,
   output logic [DWIDTH-1:0] result
);

   localparam int SW = MWIDTH + 1;
   localparam int W  = SW + 3;
   localparam logic [EWIDTH-1:0] EMAX = '1;

   logic [DWIDTH-1:0] b_eff, big, sml;
   logic [EWIDTH-1:0] be, se, diff;
   logic [SW-1:0]     bsig, ssig;
   logic [2*W-1:0]    wide;
   logic [W-1:0]      bx, sx, n;
   logic [W:0]        s;
   logic [MWIDTH:0]   mr;
   logic              rnd, inf_in, ovf;
   int                e, lz;

   always_comb begin
      b_eff = {b_operand[DWIDTH-1] ^ AddBar_Sub,
               b_operand[DWIDTH-2:0]};
      if (b_eff[DWIDTH-2:0] > a_operand[DWIDTH-2:0]) begin
         big = b_eff;
         sml = a_operand;
      end else begin
         big = a_operand;
         sml = b_eff;
      end
      bsig = {|big[DWIDTH-2:MWIDTH], big[MWIDTH-1:0]};
      ssig = {|sml[DWIDTH-2:MWIDTH], sml[MWIDTH-1:0]};
      be = (bsig[SW-1]) ? big[DWIDTH-2:MWIDTH] : EWIDTH'(1);
      se = (ssig[SW-1]) ? sml[DWIDTH-2:MWIDTH] : EWIDTH'(1);
      diff = be - se;
      bx = {bsig, 3'b000};
      wide = {ssig, 3'b000, {W{1'b0}}} >> diff;
      // shifted-out bits collapse into the sticky bit
      if (int'(diff) >= W)
         sx = {{(W-1){1'b0}}, |ssig};
      else
         sx = wide[2*W-1:W] | {{(W-1){1'b0}}, |wide[W-1:0]};
      if (big[DWIDTH-1] ^ sml[DWIDTH-1])
         s = {1'b0, bx} - {1'b0, sx};
      else
         s = {1'b0, bx} + {1'b0, sx};
      e = int'(be);
      lz = 0;
      if (s[W]) begin
         n = s[W:1] | {{(W-1){1'b0}}, s[0]};
         e = e + 1;
      end else begin
         for (int i = 0; i < W; i++)
            if (s[i]) lz = W - 1 - i;
         n = s[W-1:0] << lz;
         e = e - lz;
      end
      rnd = n[2] & (n[1] | n[0] | n[3]);
      mr = {1'b0, n[W-2:3]} + {{MWIDTH{1'b0}}, rnd};
      if (mr[MWIDTH]) e = e + 1;
      inf_in = (&a_operand[DWIDTH-2:MWIDTH])
             | (&b_operand[DWIDTH-2:MWIDTH]);
      ovf = !inf_in && n[W-1] && (e >= 2*BIAS + 1);
      Exception = inf_in | ovf;
      if (inf_in)
         result = big;
      else if (!n[W-1] || e < 1)
         result = '0;
      else if (ovf)
         result = {big[DWIDTH-1], EMAX, {MWIDTH{1'b0}}};
      else
         result = {big[DWIDTH-1], e[EWIDTH-1:0], mr[MWIDTH-1:0]};
   end

endmodule

// File: rtl/fp32_accum_ctrl.sv
// Packet accumulator around one shared fp32_add.
// Define FP32_ACC_PIPE_EN to register the adder output (adds WAIT).
module fp32_accum_ctrl
   import fp32_acc_pkg::*;
#(
   parameter int DWIDTH = DWIDTH_DEF,
   parameter int EWIDTH = EWIDTH_DEF,
   parameter int MWIDTH = MWIDTH_DEF,
   parameter int BIAS   = BIAS_DEF,
   parameter int CWIDTH = CWIDTH_DEF
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DWIDTH-1:0] s_data,
   input  logic              s_last,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DWIDTH-1:0] m_data,
   output logic [CWIDTH-1:0] m_count,
   output logic              m_exception
);

   localparam logic [CWIDTH-1:0] ONE = {{(CWIDTH-1){1'b0}}, 1'b1};

   state_t            state_q;
   logic [DWIDTH-1:0] acc_q, sum;
   logic [CWIDTH-1:0] count_q, count_d;
   logic              exc_q, add_exc;
   logic              s_ready_q, m_valid_q;
   logic              s_hs, m_hs;
`ifdef FP32_ACC_PIPE_EN
   logic [DWIDTH-1:0] sum_q;
   logic              sexc_q, last_q;
`endif

   fp32_add #(
      .DWIDTH (DWIDTH),
      .EWIDTH (EWIDTH),
      .MWIDTH (MWIDTH),
      .BIAS   (BIAS)
   ) u_fp32_add (
      .a_operand  (acc_q),
      .b_operand  (s_data),
      .AddBar_Sub (1'b0),
      .Exception  (add_exc),
      .result     (sum)
   );

   assign s_hs    = s_valid && s_ready_q;
   assign m_hs    = m_valid_q && m_ready;
   assign count_d = (&count_q) ? count_q : count_q + ONE;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= IDLE;
         acc_q     <= FP32_ZERO;
         count_q   <= '0;
         exc_q     <= 1'b0;
         s_ready_q <= 1'b1;
         m_valid_q <= 1'b0;
`ifdef FP32_ACC_PIPE_EN
         sum_q     <= FP32_ZERO;
         sexc_q    <= 1'b0;
         last_q    <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: if (s_hs) begin
               acc_q   <= s_data;
               count_q <= ONE;
               exc_q   <= 1'b0;
               if (s_last) begin
                  state_q   <= DONE;
                  s_ready_q <= 1'b0;
                  m_valid_q <= 1'b1;
               end else begin
                  state_q <= ACC;
               end
            end
            ACC: if (s_hs) begin
               count_q <= count_d;
`ifdef FP32_ACC_PIPE_EN
               sum_q     <= sum;
               sexc_q    <= add_exc;
               last_q    <= s_last;
               state_q   <= WAIT;
               s_ready_q <= 1'b0;
`else
               acc_q <= sum;
               exc_q <= exc_q | add_exc;
               if (s_last) begin
                  state_q   <= DONE;
                  s_ready_q <= 1'b0;
                  m_valid_q <= 1'b1;
               end
`endif
            end
            WAIT: begin
`ifdef FP32_ACC_PIPE_EN
               acc_q <= sum_q;
               exc_q <= exc_q | sexc_q;
               if (last_q) begin
                  state_q   <= DONE;
                  m_valid_q <= 1'b1;
               end else begin
                  state_q   <= ACC;
                  s_ready_q <= 1'b1;
               end
`else
               state_q   <= IDLE;
               s_ready_q <= 1'b1;
               m_valid_q <= 1'b0;
`endif
            end
            DONE: if (m_hs) begin
               state_q   <= IDLE;
               s_ready_q <= 1'b1;
               m_valid_q <= 1'b0;
            end
            default: begin
               state_q   <= IDLE;
               s_ready_q <= 1'b1;
               m_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign s_ready     = s_ready_q;
   assign m_valid     = m_valid_q;
   assign m_data      = acc_q;
   assign m_count     = count_q;
   assign m_exception = exc_q;

endmodule

// File: tb/tb_fp32_accum_ctrl.sv
// Scoreboard bench for fp32_accum_ctrl: directed vectors plus random
// packets checked against a real-arithmetic FP32 reference.
module tb_fp32_accum_ctrl;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        s_valid = 1'b0;
   logic        s_last = 1'b0;
   logic [31:0] s_data = 32'h0;
   logic        m_ready = 1'b1;
   logic        s_ready, m_valid, m_exception;
   logic [31:0] m_data;
   logic [15:0] m_count;

   typedef struct {
      logic [31:0] data;
      int          count;
      logic        exc;
      logic        data_x;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] pk[$];
   logic        rdy_log[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic        rand_mr = 1'b0;
   logic        mr_force = 1'b1;

   fp32_accum_ctrl dut (
      .clk         (clk),
      .rstn        (rstn),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .s_last      (s_last),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_data      (m_data),
      .m_count     (m_count),
      .m_exception (m_exception)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      #2;
      m_ready = rand_mr ? 1'($urandom_range(0, 1)) : mr_force;
   end

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   function automatic real f2r(input logic [31:0] x);
      real m, p;
      int  e;
      if (x[30:0] == 31'h0) return 0.0;
      e = int'(x[30:23]) - 127;
      m = 1.0 + real'(x[22:0]) / 8388608.0;
      p = 1.0;
      if (e > 0) repeat (e) p = p * 2.0;
      else repeat (-e) p = p / 2.0;
      return (x[31] ? -m : m) * p;
   endfunction

   function automatic logic [31:0] r2f(input real r);
      logic [63:0] d;
      logic [23:0] m;
      logic [28:0] rem;
      int          e;
      if (r == 0.0) return 32'h0;
      d = $realtobits(r);
      e = int'(d[62:52]) - 1023 + 127;
      m = {1'b1, d[51:29]};
      rem = d[28:0];
      if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && m[0])) begin
         m = m + 24'd1;
         if (m == 24'h0) begin
            m = 24'h80_0000;
            e++;
         end
      end
      return {d[63], e[7:0], m[22:0]};
   endfunction

   function automatic exp_t model_pkt();
      exp_t r;
      r.data = pk[0];
      r.count = 1;
      r.exc = 1'b0;
      for (int i = 1; i < pk.size(); i++) begin
         if ((&r.data[30:23]) || (&pk[i][30:23])) r.exc = 1'b1;
         r.data = r2f(f2r(r.data) + f2r(pk[i]));
         if (r.count < 65535) r.count++;
      end
      r.data_x = r.exc;
      return r;
   endfunction

   initial forever begin
      exp_t ex;
      @(negedge clk);
      if (rstn && m_valid && m_ready) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_result: got %0h expected none", m_data);
         end else begin
            ex = sb.pop_front();
            if (!ex.data_x) check("m_data", 64'(m_data), 64'(ex.data));
            check("m_count", 64'(m_count), 64'(ex.count));
            check("m_exception", 64'(m_exception), 64'(ex.exc));
         end
      end
   end

   task automatic send_op(input logic [31:0] d, input logic last,
                          input bit gaps);
      int t;
      if (gaps) begin
         repeat ($urandom_range(0, 2)) begin
            s_valid = 1'b0;
            @(posedge clk);
            #1;
         end
      end
      s_valid = 1'b1;
      s_data = d;
      s_last = last;
      t = 0;
      forever begin
         @(negedge clk);
         rdy_log.push_back(s_ready);
         if (s_ready) break;
         if (++t > 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL s_ready_timeout: got 0 expected 1");
            break;
         end
      end
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_last = 1'b0;
   endtask

   task automatic send_pkt(input bit gaps, input exp_t ex);
      int lat, req;
      sb.push_back(ex);
      for (int i = 0; i < pk.size(); i++)
         send_op(pk[i], i == pk.size() - 1, gaps);
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 1) rdy_log.push_back(s_ready);
         if (m_valid) begin
            lat = k;
            break;
         end
      end
`ifdef FP32_ACC_PIPE_EN
      req = (pk.size() > 1) ? 2 : 1;
`else
      req = 1;
`endif
      check("m_valid_latency", 64'(lat), 64'(req));
      @(posedge clk);
      #1;
   endtask

   function automatic exp_t mk(input logic [31:0] d, input int c,
                               input logic x, input logic dx);
      exp_t r;
      r.data = d;
      r.count = c;
      r.exc = x;
      r.data_x = dx;
      return r;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int pat;
      int req_pat;
      exp_t ex;
      repeat (3) @(posedge clk);
      #1;
      check("rst_s_ready", 64'(s_ready), 64'd1);
      check("rst_m_valid", 64'(m_valid), 64'd0);
      check("rst_m_data", 64'(m_data), 64'd0);
      check("rst_m_count", 64'(m_count), 64'd0);
      check("rst_m_exc", 64'(m_exception), 64'd0);
      rstn = 1'b1;
      @(posedge clk);
      #1;

      pk = {};
      pk.push_back(32'h3F80_0000);
      pk.push_back(32'h4000_0000);
      pk.push_back(32'h4040_0000);
      rdy_log = {};
      send_pkt(1'b0, mk(32'h40C0_0000, 3, 1'b0, 1'b0));
      pat = 0;
      foreach (rdy_log[i]) pat = pat * 2 + int'(rdy_log[i]);
      pat = pat | (rdy_log.size() << 8);
`ifdef FP32_ACC_PIPE_EN
      req_pat = 32'h51A;
`else
      req_pat = 32'h40E;
`endif
      check("s_ready_seq", 64'(pat), 64'(req_pat));

      pk = {};
      pk.push_back(32'h4376_4700);
      pk.push_back(32'h4153_38DD);
      send_pkt(1'b0, mk(32'h4381_BD47, 2, 1'b0, 1'b0));

      pk = {};
      pk.push_back(32'h4049_0FDB);
      send_pkt(1'b0, mk(32'h4049_0FDB, 1, 1'b0, 1'b0));

      pk = {};
      pk.push_back(32'h7F80_0000);
      pk.push_back(32'h3F80_0000);
      send_pkt(1'b0, mk(32'h0, 2, 1'b1, 1'b1));
      pk = {};
      pk.push_back(32'h3F80_0000);
      pk.push_back(32'h3F80_0000);
      send_pkt(1'b0, mk(32'h4000_0000, 2, 1'b0, 1'b0));

      mr_force = 1'b0;
      pk = {};
      pk.push_back(32'h3F80_0000);
      pk.push_back(32'h4040_0000);
      send_pkt(1'b0, mk(32'h4080_0000, 2, 1'b0, 1'b0));
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_m_valid", 64'(m_valid), 64'd1);
         check("bp_s_ready", 64'(s_ready), 64'd0);
         check("bp_m_data", 64'(m_data), 64'h4080_0000);
         check("bp_m_count", 64'(m_count), 64'd2);
      end
      mr_force = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("post_hs_s_ready", 64'(s_ready), 64'd1);
      check("post_hs_m_valid", 64'(m_valid), 64'd0);
      @(posedge clk);
      #1;

      send_op(32'h3F80_0000, 1'b0, 1'b0);
      send_op(32'h4000_0000, 1'b0, 1'b0);
      #2;
      rstn = 1'b0;
      #1;
      check("mid_rst_s_ready", 64'(s_ready), 64'd1);
      check("mid_rst_m_valid", 64'(m_valid), 64'd0);
      check("mid_rst_m_data", 64'(m_data), 64'd0);
      check("mid_rst_m_count", 64'(m_count), 64'd0);
      check("mid_rst_m_exc", 64'(m_exception), 64'd0);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      @(posedge clk);
      #1;
      pk = {};
      pk.push_back(32'h4000_0000);
      pk.push_back(32'h4000_0000);
      send_pkt(1'b0, mk(32'h4080_0000, 2, 1'b0, 1'b0));

      rand_mr = 1'b1;
      for (int p = 0; p < 40; p++) begin
         int len;
         len = $urandom_range(1, 8);
         pk = {};
         for (int i = 0; i < len; i++) begin
            logic [31:0] v;
            v[31] = 1'($urandom_range(0, 1));
            v[30:23] = 8'($urandom_range(120, 134));
            v[22:0] = 23'($urandom);
            pk.push_back(v);
         end
         ex = model_pkt();
         send_pkt(1'b1, ex);
      end
      rand_mr = 1'b0;
      mr_force = 1'b1;

      for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
      @(negedge clk);
      check("sb_drained", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
